// File: rtl/dkeysched_pkg.sv
// dkeysched shared definitions: FSM state codes, round count, Rcon table
// and the GF(2^8) helpers behind the AES S-box.
package dkeysched_pkg;

    localparam int NROUNDS = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_EXPAND = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    function automatic logic [7:0] rcon_byte(input logic [3:0] rc);
        logic [7:0] r;
        r = 8'h00;
        case (rc)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/dkeysched_if.sv
// dkeysched bus: key load request, indexed read port and status flags.
// master drives key_in/key_load/rd_idx; slave returns rk_out/busy/ready.
interface dkeysched_if;
    logic [127:0] key_in;
    logic         key_load;
    logic [3:0]   rd_idx;
    logic [127:0] rk_out;
    logic         busy;
    logic         ready;

    modport master (
        output key_in, key_load, rd_idx,
        input  rk_out, busy, ready
    );

    modport slave (
        input  key_in, key_load, rd_idx,
        output rk_out, busy, ready
    );
endinterface

// File: rtl/dkeysched_droundkey.sv
// droundkey: combinational AES-128 one-round key expansion step.
// inkey = round key i, rc = i (0..9), outkey = round key i+1.
module droundkey
    import dkeysched_pkg::*;
(
    input  logic [127:0] inkey,
    input  logic [3:0]   rc,
    output logic [127:0] outkey
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, tmp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0  = inkey[127:96];
        w1  = inkey[95:64];
        w2  = inkey[63:32];
        w3  = inkey[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]),
               sbox(rot[15:8]),  sbox(rot[7:0])};
        tmp = sub ^ {rcon_byte(rc), 24'h0};
        n0  = w0 ^ tmp;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        outkey = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/dkeysched.sv
// dkeysched: sequential AES-128 key schedule, one expansion step per clock,
// 11-entry round-key file with a registered indexed read port (bus.slave).
module dkeysched
    import dkeysched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    dkeysched_if.slave  bus
);

    state_t       state_q, state_d;
    logic [3:0]   rc_q, rc_d;
    logic [127:0] cur_q, cur_d;
    logic [127:0] slot_q [11];
    logic [127:0] slot_d [11];
    logic [127:0] rk_out_q, rk_out_d;
    logic         busy_q, busy_d;
    logic         ready_q, ready_d;
    logic [127:0] nk;

    droundkey u_step (
        .inkey  (cur_q),
        .rc     (rc_q),
        .outkey (nk)
    );

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        cur_d   = cur_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        for (int i = 0; i < 11; i++) slot_d[i] = slot_q[i];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.key_load) begin
                    slot_d[0] = bus.key_in;
                    cur_d     = bus.key_in;
                    rc_d      = 4'd0;
                    state_d   = ST_EXPAND;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            ST_EXPAND: begin
                for (int i = 1; i < 11; i++) begin
                    if (rc_q + 4'd1 == 4'(i)) slot_d[i] = nk;
                end
                cur_d = nk;
                rc_d  = rc_q + 4'd1;
                if (rc_q == 4'(NROUNDS - 1)) begin
                    // rc stays within 0..9; it is reloaded on the next key_load anyway
                    rc_d    = 4'd0;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux runs every cycle regardless of the FSM; out-of-range reads give 0.
    always_comb begin
        rk_out_d = '0;
        for (int i = 0; i < 11; i++) begin
            if (bus.rd_idx == 4'(i)) rk_out_d = slot_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rc_q     <= '0;
            cur_q    <= '0;
            rk_out_q <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            for (int i = 0; i < 11; i++) slot_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            rc_q     <= rc_d;
            cur_q    <= cur_d;
            rk_out_q <= rk_out_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            for (int i = 0; i < 11; i++) slot_q[i] <= slot_d[i];
        end
    end

    assign bus.rk_out = rk_out_q;
    assign bus.busy   = busy_q;
    assign bus.ready  = ready_q;

endmodule
